// File: rtl/chacha_stream_ctrl.sv
// Block sequencer around the ChaCha20 core: packs 32-bit words into 512-bit blocks,
// tags each block with its counter, starts the core and returns the masked result.
module chacha_stream_ctrl #(
  parameter int WIDTH       = 32,
  parameter int BLOCK_WIDTH = 512,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [COUNT_WIDTH-1:0] init_counter,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   core_start,
  input  logic                   core_ready,
  input  logic                   core_valid,
  output logic [COUNT_WIDTH-1:0] core_block_count,
  output logic [BLOCK_WIDTH-1:0] core_data_in,
  input  logic [BLOCK_WIDTH-1:0] core_data_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BLOCK_WIDTH-1:0] out_data,
  output logic [4:0]             out_words,
  output logic                   out_last
);
  localparam int WORDS = BLOCK_WIDTH / WIDTH;
  localparam int IDX_W = $clog2(WORDS);

  typedef enum logic [1:0] {FILL, START, WAIT, OUT} state_t;

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       index_reg;
  logic [4:0]             word_cnt_reg;
  logic [COUNT_WIDTH-1:0] counter_reg;
  logic [BLOCK_WIDTH-1:0] block_reg;
  logic [BLOCK_WIDTH-1:0] out_data_reg;
  logic [BLOCK_WIDTH-1:0] masked;
  logic [4:0]             out_words_reg;
  logic                   out_last_reg;
  logic                   in_msg_reg;
  logic                   last_reg;
  logic                   run_reg;
  logic                   accept;
  logic                   block_done;

  // run_reg keeps in_ready low until the first clock after reset release
  assign accept     = (state_reg == FILL) && run_reg && in_valid;
  assign block_done = accept && ((index_reg == IDX_W'(WORDS - 1)) || in_last);

  assign core_block_count = counter_reg;
  assign core_data_in     = block_reg;
  assign out_data         = out_data_reg;
  assign out_words        = out_words_reg;
  assign out_last         = out_last_reg;

  // Core output words beyond the message tail carry bare keystream; zero them
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_mask
    assign masked[gi*WIDTH +: WIDTH] =
      (5'(gi) < word_cnt_reg) ? core_data_out[gi*WIDTH +: WIDTH] : '0;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    core_start = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      FILL: begin
        in_ready = run_reg;
        if (block_done) state_next = START;
      end
      START: begin
        core_start = core_ready;
        if (core_ready) state_next = WAIT;
      end
      WAIT: begin
        if (core_valid) state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= FILL;
      run_reg       <= 1'b0;
      index_reg     <= '0;
      word_cnt_reg  <= '0;
      counter_reg   <= '0;
      block_reg     <= '0;
      out_data_reg  <= '0;
      out_words_reg <= '0;
      out_last_reg  <= 1'b0;
      in_msg_reg    <= 1'b0;
      last_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      run_reg   <= 1'b1;
      case (state_reg)
        FILL: begin
          if (accept) begin
            block_reg[index_reg*WIDTH +: WIDTH] <= in_data;
            index_reg  <= index_reg + 1'b1;
            in_msg_reg <= 1'b1;
            if (!in_msg_reg) counter_reg <= init_counter;
            if (block_done) begin
              word_cnt_reg <= 5'(index_reg) + 5'd1;
              last_reg     <= in_last;
            end
          end
        end
        WAIT: begin
          if (core_valid) begin
            out_data_reg  <= masked;
            out_words_reg <= word_cnt_reg;
            out_last_reg  <= last_reg;
          end
        end
        OUT: begin
          if (out_ready) begin
            block_reg     <= '0;
            index_reg     <= '0;
            out_data_reg  <= '0;
            out_words_reg <= '0;
            out_last_reg  <= 1'b0;
            // A finished message frees the counter for reload; otherwise advance it
            if (last_reg) in_msg_reg <= 1'b0;
            else          counter_reg <= counter_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Directed bench for chacha_stream_ctrl with a sequential model of the cipher core.
module tb_chacha_stream_ctrl;
  logic         clk = 1'b0;
  logic         resetn;
  logic [31:0]  init_counter;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic         core_start;
  logic         core_ready;
  logic         core_valid;
  logic [31:0]  core_block_count;
  logic [511:0] core_data_in;
  logic [511:0] core_data_out;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_data;
  logic [4:0]   out_words;
  logic         out_last;

  int total = 0;
  int passed = 0;
  int timeouts = 0;
  int start_cnt = 0;

  chacha_stream_ctrl dut (
    .clk(clk), .resetn(resetn), .init_counter(init_counter),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .core_start(core_start), .core_ready(core_ready), .core_valid(core_valid),
    .core_block_count(core_block_count), .core_data_in(core_data_in),
    .core_data_out(core_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_words(out_words), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (core_start && core_ready) start_cnt++;

  function automatic logic [31:0] ks(input int k, input logic [31:0] c);
    return (32'h9E3779B9 * 32'(k + 1)) ^ {c[15:0], c[31:16]} ^ 32'h0F1E2D3C;
  endfunction

  function automatic logic [511:0] keyblock(input logic [31:0] c);
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[32*k +: 32] = ks(k, c);
    return r;
  endfunction

  function automatic logic [511:0] exp_out(input logic [511:0] din, input int n,
                                           input logic [31:0] c);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[32*k +: 32] = din[32*k +: 32] ^ ks(k, c);
    return r;
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] base, input int i);
    return base ^ (32'(i) * 32'h01030507);
  endfunction

  // All stimulus tasks start and end on a falling edge
  task automatic put_word(input logic [31:0] d, input logic l);
    int t;
    t = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) timeouts++;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic serve_core(input int lat, output logic [31:0] cnt, output logic [511:0] din);
    int t;
    t = 0;
    #1;
    while (!core_start && t < 100) begin @(negedge clk); t++; end
    if (!core_start) timeouts++;
    cnt = core_block_count;
    din = core_data_in;
    @(posedge clk);
    @(negedge clk);
    repeat (lat) @(negedge clk);
    core_valid = 1'b1;
    core_data_out = din ^ keyblock(cnt);
    @(negedge clk);
    core_valid = 1'b0;
    core_data_out = '0;
  endtask

  task automatic take_out(output logic [511:0] d, output logic [4:0] w, output logic l);
    int t;
    t = 0;
    while (!out_valid && t < 100) begin @(negedge clk); t++; end
    if (!out_valid) timeouts++;
    d = out_data; w = out_words; l = out_last;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_message(input logic [31:0] base, input int n, input logic [31:0] init,
                             input int lat);
    int sent, b, nb;
    logic [511:0] exp_in, din, od;
    logic [31:0] cnt, exp_cnt;
    logic [4:0] ow;
    logic ol;
    sent = 0; b = 0;
    init_counter = init;
    while (sent < n) begin
      nb = (n - sent > 16) ? 16 : n - sent;
      exp_in = '0;
      exp_cnt = init + 32'(b);
      for (int k = 0; k < nb; k++) begin
        exp_in[32*k +: 32] = word_of(base, sent + k);
        put_word(word_of(base, sent + k), (sent + k == n - 1));
        init_counter = ~init;
      end
      serve_core(lat, cnt, din);
      take_out(od, ow, ol);
      total++;
      if (cnt !== exp_cnt) $display("FAIL block_count blk %0d: got %h expected %h", b, cnt, exp_cnt);
      else passed++;
      total++;
      if (din !== exp_in) $display("FAIL core_data_in blk %0d: got %h expected %h", b, din, exp_in);
      else passed++;
      total++;
      if (od !== exp_out(exp_in, nb, exp_cnt))
        $display("FAIL out_data blk %0d: got %h expected %h", b, od, exp_out(exp_in, nb, exp_cnt));
      else passed++;
      total++;
      if (ow !== 5'(nb)) $display("FAIL out_words blk %0d: got %0d expected %0d", b, ow, nb);
      else passed++;
      total++;
      if (ol !== (sent + nb == n)) $display("FAIL out_last blk %0d: got %b expected %b", b, ol, (sent + nb == n));
      else passed++;
      $display("block %0d: count=%h words=%0d last=%b", b, cnt, ow, ol);
      sent += nb;
      b++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; init_counter = '0;
    core_ready = 1'b1; core_valid = 1'b0; core_data_out = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b0) $display("FAIL reset in_ready: got %b expected 0", in_ready); else passed++;
    total++;
    if (core_start !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0)
      $display("FAIL reset flags: got start=%b valid=%b last=%b expected 0", core_start, out_valid, out_last);
    else passed++;
    total++;
    if (out_data !== '0 || out_words !== 5'd0 || core_block_count !== 32'd0 || core_data_in !== '0)
      $display("FAIL reset data: got words=%0d count=%h expected all zero", out_words, core_block_count);
    else passed++;
    resetn = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) $display("FAIL ready after release: got %b expected 1", in_ready); else passed++;
    $display("reset done");
  endtask

  task automatic test_single_word();
    timeouts = 0;
    init_counter = 32'd1;
    run_message(32'hDEADBEEF, 1, 32'd1, 3);
    total++;
    if (timeouts !== 0) $display("FAIL single timeout: got %0d expected 0", timeouts); else passed++;
  endtask

  task automatic test_full16();
    int s0;
    timeouts = 0;
    s0 = start_cnt;
    run_message(32'h11112222, 16, 32'd5, 0);
    repeat (20) @(negedge clk);
    total++;
    if (start_cnt - s0 !== 1) $display("FAIL full16 starts: got %0d expected 1", start_cnt - s0); else passed++;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL full16 idle: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
    else passed++;
    total++;
    if (timeouts !== 0) $display("FAIL full16 timeout: got %0d expected 0", timeouts); else passed++;
  endtask

  task automatic test_multi_block();
    int s0;
    timeouts = 0;
    s0 = start_cnt;
    run_message(32'hCAFE0000, 40, 32'd7, 2);
    total++;
    if (start_cnt - s0 !== 3) $display("FAIL multi starts: got %0d expected 3", start_cnt - s0); else passed++;
    total++;
    if (timeouts !== 0) $display("FAIL multi timeout: got %0d expected 0", timeouts); else passed++;
  endtask

  task automatic test_wrap();
    timeouts = 0;
    run_message(32'h0BADF00D, 20, 32'hFFFFFFFF, 1);
    total++;
    if (timeouts !== 0) $display("FAIL wrap timeout: got %0d expected 0", timeouts); else passed++;
  endtask

  task automatic test_backpressure();
    logic [511:0] exp_in, din, od, held;
    logic [31:0] cnt;
    logic [4:0] ow;
    logic ol;
    int bad_start, bad_out;
    timeouts = 0;
    bad_start = 0; bad_out = 0;
    init_counter = 32'h00000040;
    core_ready = 1'b0;
    exp_in = '0;
    for (int k = 0; k < 3; k++) begin
      exp_in[32*k +: 32] = word_of(32'h55AA0000, k);
      put_word(word_of(32'h55AA0000, k), k == 2);
    end
    repeat (5) begin
      if (core_start !== 1'b0 || core_data_in !== exp_in || core_block_count !== 32'h40) bad_start++;
      @(negedge clk);
    end
    total++;
    if (bad_start !== 0) $display("FAIL core_ready hold: got %0d bad cycles expected 0", bad_start); else passed++;
    core_ready = 1'b1;
    serve_core(1, cnt, din);
    held = out_data;
    repeat (10) begin
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || out_words !== 5'd3) bad_out++;
      @(negedge clk);
    end
    total++;
    if (bad_out !== 0) $display("FAIL out_ready hold: got %0d bad cycles expected 0", bad_out); else passed++;
    take_out(od, ow, ol);
    total++;
    if (od !== exp_out(exp_in, 3, 32'h40)) $display("FAIL bp out_data: got %h expected %h", od, exp_out(exp_in, 3, 32'h40));
    else passed++;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) $display("FAIL bp ready after out: got %b expected 1", in_ready); else passed++;
    total++;
    if (timeouts !== 0) $display("FAIL bp timeout: got %0d expected 0", timeouts); else passed++;
    $display("backpressure: count=%h words=%0d last=%b", cnt, ow, ol);
  endtask

  task automatic test_spurious();
    logic [511:0] exp_in, din, od;
    logic [31:0] cnt;
    logic [4:0] ow;
    logic ol;
    timeouts = 0;
    init_counter = 32'd20;
    core_valid = 1'b1; core_data_out = {16{32'hFFFF0000}};
    @(negedge clk);
    core_valid = 1'b0; core_data_out = '0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL spurious idle: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
    else passed++;
    exp_in = '0;
    exp_in[31:0] = 32'hA0A0A0A0;
    put_word(32'hA0A0A0A0, 1'b0);
    core_valid = 1'b1; core_data_out = {16{32'h12345678}};
    @(negedge clk);
    core_valid = 1'b0;
    exp_in[63:32] = 32'hB1B1B1B1;
    core_ready = 1'b0;
    put_word(32'hB1B1B1B1, 1'b1);
    core_valid = 1'b1;
    @(negedge clk);
    core_valid = 1'b0; core_data_out = '0;
    total++;
    if (out_valid !== 1'b0) $display("FAIL spurious start: got out_valid=%b expected 0", out_valid); else passed++;
    core_ready = 1'b1;
    serve_core(0, cnt, din);
    take_out(od, ow, ol);
    total++;
    if (od !== exp_out(exp_in, 2, 32'd20) || ow !== 5'd2 || ol !== 1'b1)
      $display("FAIL spurious result: got %h words=%0d expected %h words=2", od, ow, exp_out(exp_in, 2, 32'd20));
    else passed++;
    total++;
    if (timeouts !== 0) $display("FAIL spurious timeout: got %0d expected 0", timeouts); else passed++;
    $display("spurious: count=%h words=%0d last=%b", cnt, ow, ol);
  endtask

  task automatic test_reset_wait();
    timeouts = 0;
    init_counter = 32'd3;
    put_word(32'h77778888, 1'b1);
    #1;
    total++;
    if (core_start !== 1'b1) $display("FAIL rst_wait start: got %b expected 1", core_start); else passed++;
    @(posedge clk);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    total++;
    if (core_block_count !== 32'd0 || core_data_in !== '0 || in_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL rst_wait outputs: got count=%h ready=%b valid=%b expected 0", core_block_count, in_ready, out_valid);
    else passed++;
    @(negedge clk);
    core_valid = 1'b1; core_data_out = {16{32'hEEEEEEEE}};
    @(negedge clk);
    core_valid = 1'b0; core_data_out = '0;
    resetn = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL rst_wait release: got ready=%b valid=%b expected 1/0", in_ready, out_valid);
    else passed++;
    run_message(32'h31415926, 1, 32'd9, 1);
    total++;
    if (timeouts !== 0) $display("FAIL rst_wait timeout: got %0d expected 0", timeouts); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full16();
    test_multi_block();
    test_wrap();
    test_backpressure();
    test_spurious();
    test_reset_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/chacha_stream_ctrl.md
# chacha_stream_ctrl

Upstream/downstream controller for the ChaCha20 cipher core. It packs a 32-bit word stream into 512-bit blocks and assigns each block its block counter. It starts the core once per block, captures the XORed result, and presents it as a block-wide output stream with word count and end-of-message flag. It owns all block sequencing; the core only sees one block request at a time.

## Interface
- WIDTH, 32, input word width in bits
- BLOCK_WIDTH, 512, cipher block width; BLOCK_WIDTH/WIDTH = 16 words per block
- COUNT_WIDTH, 32, block counter width
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- init_counter  in  COUNT_WIDTH  initial block counter, sampled on the first accepted word of a message
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid && in_ready
- in_data  in  WIDTH  input word
- in_last  in  1  marks final word of message
- core_start  out  1  start request to cipher core
- core_ready  in  1  core can accept start
- core_valid  in  1  one-cycle pulse, core_data_out valid in that cycle
- core_block_count  out  COUNT_WIDTH  counter for current block
- core_data_in  out  BLOCK_WIDTH  packed plaintext block
- core_data_out  in  BLOCK_WIDTH  core result (keystream XOR data_in)
- out_valid  out  1  output block valid
- out_ready  in  1  output block consumed when out_valid && out_ready
- out_data  out  BLOCK_WIDTH  result block, unused words zeroed
- out_words  out  5  valid words in out_data, 1..16
- out_last  out  1  block is final block of message

## Operation
- FSM states: FILL, START, WAIT, OUT. Reset state is FILL.
- FILL: in_ready=1.
  - Accepted word k (k = 0..15) is written to core_data_in[32k+31:32k].
  - The word index increments on each accepted word.
  - The first word of a message loads the counter register from init_counter.
  - FILL -> START when word 15 is accepted or in_last is accepted.
  - On exit from FILL, word slots above the last written slot are zero and word_cnt = index+1.
- START: in_ready=0; core_start = core_ready (combinational). START -> WAIT in the cycle core_ready=1.
- WAIT: core_data_in and core_block_count are held stable. On core_valid, core_data_out is registered into out_data with words >= word_cnt forced to zero; then WAIT -> OUT.
- core_valid in any state other than WAIT is ignored.
- OUT: out_valid=1 and out_data, out_words, out_last are held stable until the handshake. On handshake:
  - buffer is cleared and index set to 0;
  - if out_last: the message ends and the next accepted word starts a new message (reloads from init_counter);
  - else: counter increments modulo 2^COUNT_WIDTH (0xFFFFFFFF wraps to 0, no flag);
  - then OUT -> FILL.
- A message ending exactly on word 15 produces no extra empty block. Zero-length messages do not exist; in_last always accompanies a word.
- Only one block is in flight; no overlap between fill and core processing.

## Timing
- Reset (async assert, sync release effect):
  - state=FILL, index=0, counter=0, buffers zero;
  - in_ready=0 while resetn=0, then 1 from the first cycle after release;
  - core_start=0, out_valid=0, out_data=0, out_words=0, out_last=0, core_block_count=0, core_data_in=0.
- Reset mid-operation discards all state; any in-flight core result is dropped.
- Full block: 16 accept cycles minimum. The START cycle follows the last accept; core_start is high for exactly 1 cycle when core_ready is already 1.
- out_valid rises 1 cycle after the core_valid pulse.
- in_ready rises 1 cycle after the output handshake.
- Throughput with zero-wait core and sink: 16 + 1 + core latency + 1 + 1 cycles per block.

## Test plan
- Single word: 0xDEADBEEF with in_last, init_counter=1 -> one core_start with core_block_count=1 and core_data_in[31:0]=0xDEADBEEF, rest 0. With a model core returning X: out_words=1, out_last=1, out_data words 1..15 = 0.
- Exactly 16 words, last on word 15 -> one block, out_words=16, out_last=1, no second core_start.
- 40 words, init_counter=7 -> three blocks with counters 7, 8, 9; out_words 16, 16, 8; out_last only on the third.
- Wrap: init_counter=0xFFFFFFFF, 20 words -> counters 0xFFFFFFFF then 0x00000000.
- Backpressure and stray pulses:
  - core_ready low 5 cycles -> core_start held off, core_data_in stable;
  - out_ready low 10 cycles -> out_valid and out_data stable, in_ready=0;
  - spurious core_valid in FILL -> ignored.
- Reset asserted during WAIT -> all outputs 0 immediately; after release in_ready=1 and a new message starts from init_counter.
